onchip_ram_pipelined: RTL and testbench

Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It succeeds the fixed 128x32 on-chip memory. Over its predecessor it adds:
- configurable data width, depth and read latency;
- explicit `read`, `readdatavalid` and `waitrequest` handshakes;
- write-first read-during-write forwarding;
- an optional clear engine that zeroes the whole array after reset.

It sits on the system interconnect as a data or buffer memory for the Nios II core and for custom peripherals.

---
 rtl/onchip_ram_pipelined.sv | 172 +++++++++++++++++
 tb/tb_onchip_ram_pipelined.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_pipelined.sv
// onchip_ram_pipelined
//   Parametrised single-port on-chip RAM with an Avalon-MM slave interface.
//   Byte-enabled writes, write-first read-during-write forwarding, a read
//   pipeline of 1 or 2 cycles and an optional clear engine that zero-fills
//   the array after every reset.
//
// Ports
//   clk            single clock, rising edge
//   reset_n        synchronous reset, active low
//   address        word address (wraps modulo the depth)
//   byteenable     per-byte write enable
//   chipselect     slave select
//   read / write   request strobes
//   writedata      write data
//   clken          clock enable; low freezes all state
//   readdata       read data, holds its last value between tokens
//   readdatavalid  readdata carries a returning read this cycle
//   waitrequest    slave not accepting a request this cycle
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RESET | entered on any reset edge; behaves as the first cycle of
//         | CLEAR (or as RUN without clear) once reset_n is high again
// S_CLEAR | zero-filling mem[clr_cnt], waitrequest held high
// S_RUN   | normal operation, waitrequest = ~clken

module onchip_ram_pipelined #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 7,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_RESET,
        S_CLEAR,
        S_RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_nxt;

    logic                in_clear;
    logic                in_run;
    logic                clr_we;
    logic                wr_acc;
    logic                rd_acc;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [BE_W-1:0]     mem_be;
    logic [DATA_W-1:0]   mem_wd;
    logic [DATA_W-1:0]   rd_word;

    // Preload image is picked up by the vendor memory-init flow; the array
    // itself is never reset.
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_RESET;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // S_RESET with reset_n high already does the first clear write, so the
    // clear window is exactly DEPTH cycles after reset_n rises.
    always_comb begin
        in_clear    = reset_n && ((state == S_CLEAR) ||
                                  (state == S_RESET && CLEAR_ON_RESET != 0));
        in_run      = reset_n && ((state == S_RUN) ||
                                  (state == S_RESET && CLEAR_ON_RESET == 0));
        waitrequest = ~in_run | ~clken;
        clr_we      = in_clear & clken;
        wr_acc      = chipselect & ~waitrequest & write;
        rd_acc      = chipselect & ~waitrequest & read;
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (clr_we) begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            state_nxt   = (clr_cnt == '1) ? S_RUN : S_CLEAR;
        end else if (in_run && clken) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        mem_we = clr_we | wr_acc;
        mem_wa = clr_we ? clr_cnt : address;
        mem_be = clr_we ? '1 : byteenable;
        mem_wd = clr_we ? '0 : writedata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    // Write-first: a read accepted together with a write sees the merged word.
    always_comb begin
        rd_word = mem[address];
        for (int i = 0; i < BE_W; i++) begin
            if (wr_acc && byteenable[i]) begin
                rd_word[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              p1_valid;
            logic [DATA_W-1:0] p1_data;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    p1_valid      <= 1'b0;
                    p1_data       <= '0;
                    readdatavalid <= 1'b0;
                    readdata      <= '0;
                end else if (clken) begin
                    p1_valid      <= rd_acc;
                    readdatavalid <= p1_valid;
                    if (rd_acc) begin
                        p1_data <= rd_word;
                    end
                    if (p1_valid) begin
                        readdata <= p1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    readdatavalid <= 1'b0;
                    readdata      <= '0;
                end else if (clken) begin
                    readdatavalid <= rd_acc;
                    if (rd_acc) begin
                        readdata <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
module tb_onchip_ram_pipelined;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          clken;
    logic [DW-1:0] readdata1, readdata2;
    logic          readdatavalid1, readdatavalid2;
    logic          waitrequest1, waitrequest2;

    onchip_ram_pipelined #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(readdata1), .readdatavalid(readdatavalid1),
        .waitrequest(waitrequest1)
    );

    onchip_ram_pipelined #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .readdata(readdata2), .readdatavalid(readdatavalid2),
        .waitrequest(waitrequest2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // Reference model: memory array, clear countdown and per-latency token
    // queues keyed on the number of enabled clock edges.
    typedef struct {
        int          due;
        logic [31:0] d;
    } tok_t;

    logic [31:0] mmem [DEPTH];
    tok_t        q1[$];
    tok_t        q2[$];
    int          ecount;
    int          clear_left;
    logic [31:0] er1, er2;
    bit          ev1, ev2;
    bit          model_ok;
    bit          last_en;
    bit          ws_last;

    int          errors;
    int          checks;
    int          cyc;
    logic [31:0] log1[$];
    logic [31:0] log2[$];
    int          v1_cyc[$];
    int          v2_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        last_en = reset_n && clken;
        if (!reset_n) begin
            q1.delete();
            q2.delete();
            er1        = '0;
            er2        = '0;
            clear_left = DEPTH;
            model_ok   = 1'b1;
        end else if (clken) begin
            ecount++;
            while (q1.size() > 0 && q1[0].due < ecount) void'(q1.pop_front());
            while (q2.size() > 0 && q2[0].due < ecount) void'(q2.pop_front());
            if (clear_left > 0) begin
                mmem[DEPTH - clear_left] = '0;
                clear_left--;
            end else if (chipselect) begin
                if (write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) mmem[address][8*b +: 8] = writedata[8*b +: 8];
                    end
                end
                if (read) begin
                    q1.push_back('{due: ecount,     d: mmem[address]});
                    q2.push_back('{due: ecount + 1, d: mmem[address]});
                end
            end
        end
        ev1 = (q1.size() > 0) && (q1[0].due == ecount);
        ev2 = (q2.size() > 0) && (q2[0].due == ecount);
        if (ev1) er1 = q1[0].d;
        if (ev2) er2 = q2[0].d;
    endtask

    task automatic step();
        bit exp_w;
        @(negedge clk);
        ws_last = waitrequest1;
        if (model_ok) begin
            exp_w = !reset_n || (clear_left > 0) || !clken;
            chk("waitrequest_l1", {31'd0, waitrequest1}, {31'd0, exp_w});
            chk("waitrequest_l2", {31'd0, waitrequest2}, {31'd0, exp_w});
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (model_ok) begin
            chk("readdatavalid_l1", {31'd0, readdatavalid1}, {31'd0, ev1});
            chk("readdatavalid_l2", {31'd0, readdatavalid2}, {31'd0, ev2});
            chk("readdata_l1", readdata1, er1);
            chk("readdata_l2", readdata2, er2);
        end
        if (last_en && readdatavalid1) begin
            log1.push_back(readdata1);
            v1_cyc.push_back(cyc);
        end
        if (last_en && readdatavalid2) begin
            log2.push_back(readdata2);
            v2_cyc.push_back(cyc);
        end
    endtask

    task automatic idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic set_op(input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        chipselect = 1'b1;
        read       = r;
        write      = w;
        address    = a;
        byteenable = be;
        writedata  = d;
    endtask

    task automatic clear_logs();
        log1.delete();
        log2.delete();
        v1_cyc.delete();
        v2_cyc.delete();
    endtask

    // Releases reset and counts cycles with waitrequest high (bounded).
    task automatic count_clear(input string name);
        int wcnt;
        wcnt    = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!ws_last) break;
            wcnt++;
        end
        chk(name, wcnt, 16);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    initial begin
        int acc_cyc;

        vt[0]  = '{0, 1, 4'd5,  4'b1111, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{0, 1, 4'd5,  4'b0101, 32'h11223344, 32'h0};
        vt[2]  = '{1, 0, 4'd5,  4'b0000, 32'h0,        32'hDE22BE44};
        vt[3]  = '{0, 1, 4'd3,  4'b1111, 32'hAAAAAAAA, 32'h0};
        vt[4]  = '{1, 1, 4'd3,  4'b0011, 32'h55555555, 32'hAAAA5555};
        vt[5]  = '{1, 0, 4'd3,  4'b0000, 32'h0,        32'hAAAA5555};
        vt[6]  = '{0, 1, 4'd9,  4'b1000, 32'hCAFEF00D, 32'h0};
        vt[7]  = '{1, 0, 4'd9,  4'b0000, 32'h0,        32'hCA000000};
        vt[8]  = '{0, 1, 4'd15, 4'b1111, 32'h12345678, 32'h0};
        vt[9]  = '{1, 0, 4'd15, 4'b0000, 32'h0,        32'h12345678};
        vt[10] = '{1, 1, 4'd15, 4'b0010, 32'h0000AB00, 32'h1234AB78};

        errors     = 0;
        checks     = 0;
        cyc        = 0;
        ecount     = 0;
        clear_left = DEPTH;
        model_ok   = 1'b0;
        er1        = '0;
        er2        = '0;
        reset_n    = 1'b0;
        clken      = 1'b1;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        idle();

        // Reset, then clear window length
        repeat (3) step();
        chk("reset_readdata", readdata2, 32'h0);
        count_clear("clear_cycles");

        // All addresses read back zero, L1 valid one cycle after acceptance
        clear_logs();
        for (int a = 0; a < DEPTH; a++) begin
            set_op(1, 0, a[AW-1:0], 4'h0, 32'h0);
            step();
            if (a == 0) acc_cyc = cyc;
        end
        idle();
        repeat (3) step();
        chk("clear_read_count", log1.size(), DEPTH);
        for (int a = 0; a < log1.size(); a++) chk("clear_read_data", log1[a], 32'h0);
        if (v1_cyc.size() > 0) chk("clear_read_latency_l1", v1_cyc[0], acc_cyc);

        // Table of directed transactions
        for (int i = 0; i < 11; i++) begin
            clear_logs();
            set_op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].be, vt[i].wdata);
            step();
            idle();
            if (vt[i].rd) begin
                repeat (2) step();
                chk("vec_count_l1", log1.size(), 1);
                chk("vec_count_l2", log2.size(), 1);
                if (log1.size() > 0) chk("vec_data_l1", log1[0], vt[i].exp);
                if (log2.size() > 0) chk("vec_data_l2", log2[0], vt[i].exp);
            end
        end

        // Back-to-back reads, latency and throughput
        for (int a = 0; a < 8; a++) begin
            set_op(0, 1, a[AW-1:0], 4'hF, 32'h100 + a);
            step();
        end
        clear_logs();
        for (int a = 0; a < 8; a++) begin
            set_op(1, 0, a[AW-1:0], 4'h0, 32'h0);
            step();
            if (a == 0) acc_cyc = cyc;
        end
        idle();
        repeat (3) step();
        chk("burst_count_l2", log2.size(), 8);
        for (int a = 0; a < log2.size(); a++) begin
            chk("burst_data_l2", log2[a], 32'h100 + a);
            chk("burst_cycle_l2", v2_cyc[a], acc_cyc + 1 + a);
        end
        chk("burst_count_l1", log1.size(), 8);
        for (int a = 0; a < log1.size(); a++) chk("burst_data_l1", log1[a], 32'h100 + a);

        // clken stall with two reads in flight
        clear_logs();
        set_op(1, 0, 4'd2, 4'h0, 32'h0);
        step();
        set_op(1, 0, 4'd6, 4'h0, 32'h0);
        step();
        idle();
        clken = 1'b0;
        repeat (4) step();
        clken = 1'b1;
        repeat (3) step();
        chk("stall_count_l1", log1.size(), 2);
        chk("stall_count_l2", log2.size(), 2);
        if (log2.size() == 2) begin
            chk("stall_first_l2", log2[0], 32'h102);
            chk("stall_second_l2", log2[1], 32'h106);
        end

        // Reset with a read in flight, then reset mid-clear at counter 7
        set_op(1, 0, 4'd1, 4'h0, 32'h0);
        step();
        idle();
        clear_logs();
        reset_n = 1'b0;
        repeat (2) step();
        chk("flush_no_valid_l2", log2.size(), 0);
        reset_n = 1'b1;
        repeat (7) step();
        reset_n = 1'b0;
        step();
        chk("midclear_no_valid", log1.size() + log2.size(), 0);
        count_clear("clear_restart_cycles");

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            clken      = ($urandom_range(0, 7) != 0);
            chipselect = $urandom_range(0, 3) != 0;
            read       = $urandom_range(0, 1);
            write      = $urandom_range(0, 1);
            address    = AW'($urandom_range(0, DEPTH - 1));
            byteenable = 4'($urandom_range(0, 15));
            writedata  = $urandom;
            step();
        end
        clken = 1'b1;
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
